// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing generator. Free-running horizontal and
//             vertical counters produce active-low sync pulses. A pixel
//             request (data_req with pixel_xpos/pixel_ypos) is issued one
//             cycle ahead of the active window. This lead covers the
//             one-cycle latency of the display stage that returns
//             pixel_data. Colour is blanked outside the active window.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    vga_clk     in   1   pixel clock (only clock)
//    sys_rst     in   1   synchronous active-high reset
//    pixel_data  in  12   RGB444 colour, one cycle after the request
//    vga_hs      out  1   horizontal sync, active low
//    vga_vs      out  1   vertical sync, active low
//    vga_rgb     out 12   colour to DAC, 0 while blanking
//    pixel_xpos  out 10   requested column (0 when no request)
//    pixel_ypos  out 10   requested row    (0 when no request)
//    data_req    out  1   pixel request valid this cycle
//    frame_start out  1   high for the single cycle at counter (0,0)
//    frame_cnt   out  8   completed frames, modulo 256
// ============================================================================
module vga_timing_gen #(
  parameter logic [9:0] H_SYNC  = 10'd96,
  parameter logic [9:0] H_BACK  = 10'd48,
  parameter logic [9:0] H_DISP  = 10'd640,
  parameter logic [9:0] H_FRONT = 10'd16,
  parameter logic [9:0] V_SYNC  = 10'd2,
  parameter logic [9:0] V_BACK  = 10'd33,
  parameter logic [9:0] V_DISP  = 10'd480,
  parameter logic [9:0] V_FRONT = 10'd10
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [11:0] pixel_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [11:0] vga_rgb,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  // Line / frame geometry. All values fit in 10 bits for standard modes.
  localparam logic [9:0] c_H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [9:0] c_V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [9:0] c_H_ACT_START = H_SYNC + H_BACK;
  localparam logic [9:0] c_H_ACT_END   = H_SYNC + H_BACK + H_DISP;   // exclusive
  localparam logic [9:0] c_V_ACT_START = V_SYNC + V_BACK;
  localparam logic [9:0] c_V_ACT_END   = V_SYNC + V_BACK + V_DISP;   // exclusive

  // The request window leads the active window by one pixel clock.
  localparam logic [9:0] c_H_REQ_START = c_H_ACT_START - 10'd1;
  localparam logic [9:0] c_H_REQ_END   = c_H_ACT_END - 10'd1;        // exclusive

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [7:0] r_frame_cnt;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_h_active;
  logic       w_v_active;
  logic       w_h_req;
  logic       w_active;
  logic       w_data_req;

  assign w_h_last = (r_h_cnt == c_H_TOTAL - 10'd1);
  assign w_v_last = (r_v_cnt == c_V_TOTAL - 10'd1);

  // --------------------------------------------------------------------------
  // Raster counters. Reset forces (0,0) from any position. The vertical
  // counter and the frame counter advance only on the horizontal wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_h_cnt     <= 10'd0;
      r_v_cnt     <= 10'd0;
      r_frame_cnt <= 8'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 10'd0;
      if (w_v_last) begin
        r_v_cnt     <= 10'd0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Window decodes. Every output is derived from the registered counters
  // only; pixel_data reaches vga_rgb alone.
  // --------------------------------------------------------------------------
  assign w_h_active = (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END);
  assign w_v_active = (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
  assign w_h_req    = (r_h_cnt >= c_H_REQ_START) && (r_h_cnt < c_H_REQ_END);
  assign w_active   = w_h_active && w_v_active;
  assign w_data_req = w_h_req && w_v_active;

  assign vga_hs      = (r_h_cnt >= H_SYNC);
  assign vga_vs      = (r_v_cnt >= V_SYNC);
  assign data_req    = w_data_req;
  assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign frame_cnt   = r_frame_cnt;

  // Offsetting by the request start makes the first request column 0.
  assign pixel_xpos = w_data_req ? (r_h_cnt - c_H_REQ_START) : 10'd0;
  assign pixel_ypos = w_data_req ? (r_v_cnt - c_V_ACT_START) : 10'd0;

  // The request was issued one cycle earlier, so the returned colour lines
  // up with the active window here.
  assign vga_rgb = w_active ? pixel_data : 12'h000;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen using a reduced raster
//             so that hundreds of frames fit in a short run.
//             H: sync 4, back 3, disp 8, front 2 -> 17 clocks per line
//             V: sync 2, back 2, disp 4, front 1 ->  9 lines per frame
//             Active h 7..14, request h 6..13, active v 4..7,
//             153 clocks per frame, 32 active pixels per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int c_HT      = 17;
  localparam int c_VT      = 9;
  localparam int c_FRAME   = 153;

  logic        vga_clk;
  logic        sys_rst;
  logic [11:0] pixel_data;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_rgb;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        data_req;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int          checks;
  int          errors;

  // Reference raster position tracked by the bench.
  int          mh;
  int          mv;
  logic [7:0]  mf;

  vga_timing_gen #(
    .H_SYNC  (10'd4),
    .H_BACK  (10'd3),
    .H_DISP  (10'd8),
    .H_FRONT (10'd2),
    .V_SYNC  (10'd2),
    .V_BACK  (10'd2),
    .V_DISP  (10'd4),
    .V_FRONT (10'd1)
  ) u_dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .pixel_data  (pixel_data),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_rgb     (vga_rgb),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .data_req    (data_req),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // One clock; sample point is 2 time units after the rising edge.
  task automatic tick();
    @(posedge vga_clk);
    #2;
  endtask

  task automatic step();
    tick();
    if (mh == c_HT - 1) begin
      mh = 0;
      if (mv == c_VT - 1) begin
        mv = 0;
        mf = mf + 8'd1;
      end else begin
        mv = mv + 1;
      end
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    mh = 0;
    mv = 0;
    mf = 8'd0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    pixel_data = 12'hFFF;
    sys_rst    = 1'b1;
    tick();
    tick();
    checks++;
    if (vga_hs !== 1'b0 || vga_vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync hs=%b vs=%b exp 0 0", vga_hs, vga_vs);
    end
    checks++;
    if (vga_rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h exp 000", vga_rgb);
    end
    checks++;
    if (data_req !== 1'b0 || pixel_xpos !== 10'd0 || pixel_ypos !== 10'd0) begin
      errors++;
      $display("FAIL reset_req req=%b x=%0d y=%0d exp 0 0 0", data_req, pixel_xpos, pixel_ypos);
    end
    checks++;
    if (frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame fs=%b fc=%0d exp 1 0", frame_start, frame_cnt);
    end
    sys_rst = 1'b0;
    mh = 0;
    mv = 0;
    mf = 8'd0;
    step();
    checks++;
    if (frame_start !== 1'b0 || vga_hs !== 1'b0) begin
      errors++;
      $display("FAIL reset_release fs=%b hs=%b exp 0 0", frame_start, vga_hs);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hsync();
    int lows;
    logic exp_hs;
    lows = 0;
    do_reset();
    for (int i = 0; i < 3 * c_HT; i++) begin
      exp_hs = (mh < 4) ? 1'b0 : 1'b1;
      if (vga_hs === 1'b0) lows++;
      checks++;
      if (vga_hs !== exp_hs) begin
        errors++;
        $display("FAIL hsync h=%0d v=%0d got %b exp %b", mh, mv, vga_hs, exp_hs);
      end
      step();
    end
    checks++;
    if (lows != 12) begin
      errors++;
      $display("FAIL hsync_low_count got %0d exp 12", lows);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_vsync_frames();
    int lows;
    int pulses;
    logic exp_vs;
    logic exp_fs;
    lows   = 0;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 2 * c_FRAME; i++) begin
      exp_vs = (mv < 2) ? 1'b0 : 1'b1;
      exp_fs = (mh == 0 && mv == 0) ? 1'b1 : 1'b0;
      if (vga_vs === 1'b0) lows++;
      if (frame_start === 1'b1) pulses++;
      checks++;
      if (vga_vs !== exp_vs || frame_start !== exp_fs || frame_cnt !== mf) begin
        errors++;
        $display("FAIL vsync_frame h=%0d v=%0d vs=%b/%b fs=%b/%b fc=%0d/%0d",
                 mh, mv, vga_vs, exp_vs, frame_start, exp_fs, frame_cnt, mf);
      end
      step();
    end
    checks++;
    if (lows != 68) begin
      errors++;
      $display("FAIL vsync_low_count got %0d exp 68", lows);
    end
    checks++;
    if (pulses != 2 || frame_start !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL frame_two pulses=%0d fs=%b fc=%0d exp 2 1 2", pulses, frame_start, frame_cnt);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_data_req();
    logic       exp_req;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    int         reqs;
    reqs = 0;
    do_reset();
    for (int i = 0; i < c_FRAME; i++) begin
      exp_req = (mh >= 6 && mh <= 13 && mv >= 4 && mv <= 7);
      exp_x   = exp_req ? 10'(mh - 6) : 10'd0;
      exp_y   = exp_req ? 10'(mv - 4) : 10'd0;
      if (data_req === 1'b1) reqs++;
      checks++;
      if (data_req !== exp_req || pixel_xpos !== exp_x || pixel_ypos !== exp_y) begin
        errors++;
        $display("FAIL data_req h=%0d v=%0d req=%b/%b x=%0d/%0d y=%0d/%0d",
                 mh, mv, data_req, exp_req, pixel_xpos, exp_x, pixel_ypos, exp_y);
      end
      // Hand-picked boundary points.
      if (mh == 6 && mv == 4) begin
        checks++;
        if (data_req !== 1'b1 || pixel_xpos !== 10'd0 || pixel_ypos !== 10'd0) begin
          errors++;
          $display("FAIL req_first req=%b x=%0d y=%0d exp 1 0 0", data_req, pixel_xpos, pixel_ypos);
        end
      end
      if (mh == 13 && mv == 4) begin
        checks++;
        if (data_req !== 1'b1 || pixel_xpos !== 10'd7) begin
          errors++;
          $display("FAIL req_last req=%b x=%0d exp 1 7", data_req, pixel_xpos);
        end
      end
      if (mh == 14 && mv == 4) begin
        checks++;
        if (data_req !== 1'b0) begin
          errors++;
          $display("FAIL req_after_last req=%b exp 0", data_req);
        end
      end
      if (mh == 6 && mv == 7) begin
        checks++;
        if (pixel_ypos !== 10'd3) begin
          errors++;
          $display("FAIL req_last_row y=%0d exp 3", pixel_ypos);
        end
      end
      if (mh == 6 && mv == 8) begin
        checks++;
        if (data_req !== 1'b0) begin
          errors++;
          $display("FAIL req_front_porch req=%b exp 0", data_req);
        end
      end
      step();
    end
    checks++;
    if (reqs != 32) begin
      errors++;
      $display("FAIL req_count got %0d exp 32", reqs);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rgb();
    int         white;
    logic       act;
    logic [11:0] exp_rgb;
    white = 0;
    do_reset();
    // Constant white: exactly the active pixels light up.
    pixel_data = 12'hFFF;
    for (int i = 0; i < c_FRAME; i++) begin
      act = (mh >= 7 && mh <= 14 && mv >= 4 && mv <= 7);
      if (vga_rgb === 12'hFFF) white++;
      checks++;
      if (vga_rgb !== (act ? 12'hFFF : 12'h000)) begin
        errors++;
        $display("FAIL rgb_white h=%0d v=%0d got %h", mh, mv, vga_rgb);
      end
      step();
    end
    checks++;
    if (white != 32) begin
      errors++;
      $display("FAIL rgb_white_count got %0d exp 32", white);
    end
    // Varying colour: passed through inside the window, blanked outside.
    for (int i = 0; i < c_FRAME; i++) begin
      pixel_data = 12'($urandom_range(1, 4095));
      #1;
      act     = (mh >= 7 && mh <= 14 && mv >= 4 && mv <= 7);
      exp_rgb = act ? pixel_data : 12'h000;
      checks++;
      if (vga_rgb !== exp_rgb) begin
        errors++;
        $display("FAIL rgb_pass h=%0d v=%0d got %h exp %h", mh, mv, vga_rgb, exp_rgb);
      end
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < c_FRAME + 5 * c_HT + 9; i++) step();
    pixel_data = 12'hFFF;
    #1;
    checks++;
    if (frame_cnt !== 8'd1 || vga_rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL midrst_before fc=%0d rgb=%h exp 1 fff", frame_cnt, vga_rgb);
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    mh = 0;
    mv = 0;
    mf = 8'd0;
    checks++;
    if (vga_rgb !== 12'h000 || frame_cnt !== 8'd0 || frame_start !== 1'b1 ||
        vga_hs !== 1'b0 || vga_vs !== 1'b0 || data_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after rgb=%h fc=%0d fs=%b hs=%b vs=%b req=%b exp 000 0 1 0 0 0",
               vga_rgb, frame_cnt, frame_start, vga_hs, vga_vs, data_req);
    end
    for (int i = 0; i < 6 * c_HT; i++) begin
      step();
      checks++;
      if (vga_hs !== ((mh < 4) ? 1'b0 : 1'b1) ||
          vga_rgb !== ((mh >= 7 && mh <= 14 && mv >= 4 && mv <= 7) ? 12'hFFF : 12'h000)) begin
        errors++;
        $display("FAIL midrst_resume h=%0d v=%0d hs=%b rgb=%h", mh, mv, vga_hs, vga_rgb);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_frame_wrap();
    int   pulses;
    logic prev_fs;
    pulses  = 0;
    prev_fs = 1'b1;
    do_reset();
    for (int i = 0; i < 256 * c_FRAME; i++) begin
      step();
      if (frame_start === 1'b1) pulses++;
      if (prev_fs === 1'b1 && frame_start === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL fs_width two-cycle pulse at h=%0d v=%0d", mh, mv);
      end
      prev_fs = frame_start;
      if (i == 256 * c_FRAME - 2) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          errors++;
          $display("FAIL fc_before_wrap got %0d exp 255", frame_cnt);
        end
      end
      if (mh == 0) begin
        checks++;
        if (frame_cnt !== mf) begin
          errors++;
          $display("FAIL fc_track v=%0d got %0d exp %0d", mv, frame_cnt, mf);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL fc_wrap fc=%0d fs=%b exp 0 1", frame_cnt, frame_start);
    end
    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL fs_count got %0d exp 256", pulses);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    sys_rst    = 1'b1;
    pixel_data = 12'h000;
    mh         = 0;
    mv         = 0;
    mf         = 8'd0;
    test_reset();
    test_hsync();
    test_vsync_frames();
    test_data_req();
    test_rgb();
    test_mid_reset();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
